ibex_avalon_bus_arbiter: RTL
============================

Name: ibex_avalon_bus_arbiter

Overview:
- Shares one pipelined Avalon-MM master port between the Ibex instruction-fetch and data bus ports that the core wrapper exposes.
- Arbitrates commands round-robin and holds each command stable across waitrequest.
- Tracks outstanding transactions in an in-order tag FIFO and steers each read or write response back to the requester that issued it.
- Sits between the core wrapper and a single-ported interconnect/memory slave.

Parameters:
MAX_OUTSTANDING, 4, depth of the outstanding-transaction tag FIFO (power of 2, 2..16)
ADDR_W, 32, address width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
instr_read_i  in  1  instruction fetch request
instr_addr_i  in  ADDR_W  fetch address
instr_busy_o  out  1  fetch request not accepted this cycle
instr_rvalid_o  out  1  fetch read data valid
instr_rdata_o  out  32  fetch read data
data_read_i  in  1  data read request
data_write_i  in  1  data write request
data_addr_i  in  ADDR_W  data address
data_be_i  in  4  byte enables
data_wdata_i  in  32  write data
data_busy_o  out  1  data request not accepted this cycle
data_rvalid_o  out  1  data read data valid
data_rdata_o  out  32  data read data
data_resp_o  out  2  Avalon response code for the data transaction
data_wrespvalid_o  out  1  write response valid
avm_address_o  out  ADDR_W  master address
avm_read_o  out  1  master read
avm_write_o  out  1  master write
avm_byteenable_o  out  4  master byte enables
avm_writedata_o  out  32  master write data
avm_waitrequest_i  in  1  slave stall
avm_readdata_i  in  32  slave read data
avm_readdatavalid_i  in  1  read response valid
avm_writeresponsevalid_i  in  1  write response valid
avm_response_i  in  2  response code
err_unexpected_o  out  1  sticky: response arrived with the FIFO empty, or both response valids asserted together

Behaviour:
- Reset, asynchronous on rst_i=1, all cleared:
  - FIFO empty, count=0.
  - lock=0; rr pointer=instr-preferred.
  - err_unexpected_o=0.
  - avm_read_o=0, avm_write_o=0.
  - All valid outputs =0.
- Reset mid-operation drops all in-flight tags. Responses that arrive after reset deassertion with the FIFO empty set err_unexpected_o.
- Instruction requests carry byteenable 4'hF and writedata 0.
- Command path, combinational from the selected requester to avm_*:
  - avm_read_o/avm_write_o are asserted only when owner is valid and count<MAX_OUTSTANDING.
  - At count==MAX_OUTSTANDING, no command is issued and both requesters see busy. This holds even if a response pops in the same cycle.
- Owner selection:
  - lock=1: owner = locked requester. Keeps the command stable while waitrequest is high, per the Avalon rule.
  - lock=0, one requester active: that requester.
  - lock=0, both active: the rr pointer picks.
- Acceptance: accept = (avm_read_o|avm_write_o) & ~avm_waitrequest_i.
  - On accept: push tag {src, is_write}, set lock=0, and set the rr pointer to favour the non-owner.
  - Issued but stalled: lock=1 with locked owner recorded.
- Busy outputs: x_busy_o = x_request & ~(accept & owner==x). Zero-cycle grant is possible.
- Response routing:
  - avm_readdatavalid_i or avm_writeresponsevalid_i pops the FIFO head, in order.
  - Head src=instr: instr_rvalid_o=1, instr_rdata_o=avm_readdata_i.
  - Head src=data, read: data_rvalid_o=1.
  - Head src=data, write: data_wrespvalid_o=1.
  - Data responses also drive data_resp_o=avm_response_i.
  - Response outputs are combinational, same cycle as the slave response.
  - rdata outputs pass avm_readdata_i through at all times; they are qualified only by the valids.
- Simultaneous push and pop: count unchanged, pointers both advance.
- Pointer wrap: read and write pointers wrap modulo MAX_OUTSTANDING.
- Error cases:
  - Pop with FIFO empty: no response forwarded, count stays 0, err_unexpected_o=1.
  - Both response valids in the same cycle: single pop, forwarded as a read, err_unexpected_o=1.
- Head-of-line rule: a response type that mismatches the head's is_write is still forwarded by the head tag. The debug-visible error is not raised in this case.

Test Plan:
- Single fetch, addr 0x100, waitrequest=0, readdatavalid 2 cycles later with 0xDEADBEEF:
  - instr_busy_o=0 on the request cycle.
  - instr_rvalid_o=1 with 0xDEADBEEF on the response cycle; data side silent.
- Instr and data reads requested together each cycle, no stall:
  - Grants alternate instr, data, instr, data.
  - Responses returned in order are routed to the matching side.
- Data write 0x200, be 4'b0011, waitrequest high for 3 cycles while instr also requests:
  - avm_* hold write/0x200/0x3 stable for 4 cycles; instr_busy_o=1 throughout.
  - Instr is granted the cycle after acceptance.
- MAX_OUTSTANDING=4: issue 4 reads with no responses:
  - Fifth request sees busy=1 and avm_read_o=0.
  - One response frees a slot; the fifth read issues the following cycle.
- avm_writeresponsevalid_i pulse with the FIFO empty:
  - err_unexpected_o rises and stays 1 until rst_i; no valid output pulses.
- Assert rst_i with 2 reads outstanding:
  - Outputs clear asynchronously; after release a new fetch issues immediately.
  - A late stale response sets err_unexpected_o.

Source files
------------

// File: rtl/ibex_avalon_bus_arbiter.sv
// Round-robin arbiter sharing one pipelined Avalon-MM master between Ibex fetch and data ports.
// In-order tag FIFO steers each read/write response back to the requester that issued it.
module ibex_avalon_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_read_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_busy_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  input  logic              data_read_i,
  input  logic              data_write_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_busy_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic [1:0]        data_resp_o,
  output logic              data_wrespvalid_o,
  output logic [ADDR_W-1:0] avm_address_o,
  output logic              avm_read_o,
  output logic              avm_write_o,
  output logic [3:0]        avm_byteenable_o,
  output logic [31:0]       avm_writedata_o,
  input  logic              avm_waitrequest_i,
  input  logic [31:0]       avm_readdata_i,
  input  logic              avm_readdatavalid_i,
  input  logic              avm_writeresponsevalid_i,
  input  logic [1:0]        avm_response_i,
  output logic              err_unexpected_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic src_data;
    logic is_write;
  } tag_t;

  typedef enum logic [1:0] {LK_NONE, LK_INSTR, LK_DATA} lock_e;

  lock_e            lock_q, lock_d;
  logic             rr_data_q, rr_data_d;
  tag_t             fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic instr_req, data_req, owner_valid, owner_data;
  logic slot_free, issue, accept;
  logic rsp_any, rsp_both, fifo_empty, pop;
  tag_t head;

  assign instr_req = instr_read_i;
  assign data_req  = data_read_i | data_write_i;

  // Owner selection: a stalled command keeps its owner until accepted.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = 1'b0;
    unique case (lock_q)
      LK_INSTR: owner_valid = instr_req;
      LK_DATA: begin
        owner_valid = data_req;
        owner_data  = 1'b1;
      end
      default: begin
        if (instr_req && data_req) begin
          owner_valid = 1'b1;
          owner_data  = rr_data_q;
        end else if (data_req) begin
          owner_valid = 1'b1;
          owner_data  = 1'b1;
        end else begin
          owner_valid = instr_req;
        end
      end
    endcase
  end

  assign slot_free = cnt_q < CNT_W'(MAX_OUTSTANDING);
  assign issue     = owner_valid & slot_free & ~rst_i;
  assign accept    = issue & ~avm_waitrequest_i;

  assign avm_write_o      = issue & owner_data & data_write_i;
  assign avm_read_o       = issue & ~(owner_data & data_write_i);
  assign avm_address_o    = owner_data ? data_addr_i : instr_addr_i;
  assign avm_byteenable_o = owner_data ? data_be_i : 4'hF;
  assign avm_writedata_o  = owner_data ? data_wdata_i : 32'h0;

  assign instr_busy_o = instr_req & ~(accept & ~owner_data);
  assign data_busy_o  = data_req & ~(accept & owner_data);

  // Lock / round-robin next state.
  always_comb begin
    lock_d    = LK_NONE;
    rr_data_d = rr_data_q;
    if (issue) begin
      if (avm_waitrequest_i) begin
        lock_d = owner_data ? LK_DATA : LK_INSTR;
      end else begin
        rr_data_d = ~owner_data;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q    <= LK_NONE;
      rr_data_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      rr_data_q <= rr_data_d;
    end
  end

  // Response steering follows the head tag; both valids together count as a read.
  assign rsp_any    = avm_readdatavalid_i | avm_writeresponsevalid_i;
  assign rsp_both   = avm_readdatavalid_i & avm_writeresponsevalid_i;
  assign fifo_empty = (cnt_q == '0);
  assign pop        = rsp_any & ~fifo_empty;
  assign head       = fifo_q[rptr_q];

  assign instr_rvalid_o    = pop & ~head.src_data;
  assign data_rvalid_o     = pop & head.src_data & (rsp_both | ~head.is_write);
  assign data_wrespvalid_o = pop & head.src_data & ~rsp_both & head.is_write;
  assign instr_rdata_o     = avm_readdata_i;
  assign data_rdata_o      = avm_readdata_i;
  assign data_resp_o       = avm_response_i;
  assign err_unexpected_o  = err_q;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_q[wptr_q] <= '{src_data: owner_data, is_write: avm_write_o};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)    rptr_q <= rptr_q + PTR_W'(1);
      unique case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      err_q <= err_q | (rsp_any & fifo_empty) | rsp_both;
    end
  end

endmodule
